// File: rtl/pc_sequencer_pkg.sv
// Shared word width, memory-timeout default and state encoding for the PC sequencer.
// Build option PC_SEQ_STEP_EN adds the STEP state used for single-stepping.
package pc_sequencer_pkg;

  localparam int WORD            = 16;
  localparam int MEM_TIMEOUT_DEF = 8;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_MEM    = 4'd3,
    S_DECODE = 4'd4,
    S_EXEC   = 4'd5,
    S_WB     = 4'd6,
    S_HALT   = 4'd7
`ifdef PC_SEQ_STEP_EN
    ,
    S_STEP   = 4'd8
`endif
  } seq_state_e;

  // One spare bit so the counter can saturate above the terminal value.
  function automatic int tmo_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory, decode/execute and program_counter control signals of the sequencer.
// master = sequencer side, slave = memory/decoder/execute/program_counter side.
interface pc_sequencer_if import pc_sequencer_pkg::*; #(
  parameter int WIDTH = WORD
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;

  logic             dec_valid;
  logic             dec_jump;
  logic             dec_rjump;
  logic             dec_halt;
  logic [WIDTH-1:0] dec_target;
  logic [WIDTH-1:0] dec_offset;

  logic             exec_done;

  logic             PC_fetch;
  logic             jump;
  logic             rjump;
  logic             PC_wb_tr;
  logic [WIDTH-1:0] jump_loc;
  logic [WIDTH-1:0] jump_inc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack,
    input  dec_valid, dec_jump, dec_rjump, dec_halt, dec_target, dec_offset,
    input  exec_done,
    output PC_fetch, jump, rjump, PC_wb_tr, jump_loc, jump_inc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack,
    output dec_valid, dec_jump, dec_rjump, dec_halt, dec_target, dec_offset,
    output exec_done,
    input  PC_fetch, jump, rjump, PC_wb_tr, jump_loc, jump_inc
  );

endinterface

// File: rtl/pc_sequencer_timeout_ctr.sv
// Loadable saturating up-counter with clear/enable; term flags count == TIMEOUT-1.
// Clear wins over load, load wins over enable.
module seq_timeout_ctr import pc_sequencer_pkg::*; #(
  parameter  int TIMEOUT = MEM_TIMEOUT_DEF,
  localparam int CW      = tmo_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          term
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

  assign term = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller for program_counter: one PC update per instruction.
// Build option PC_SEQ_STEP_EN adds the step input and a STEP state between WB and FETCH.
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter int WIDTH       = WORD,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef PC_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [WIDTH-1:0] pc_loc,
  pc_sequencer_if.master   bus,
  output logic             halted,
  output logic             fault
);

  // state  | meaning
  // IDLE   | wait for run          FETCH  | PC_fetch strobe        LATCH | imem_addr <= pc_loc
  // MEM    | imem_req until ack    DECODE | wait dec_valid, latch  EXEC  | wait exec_done
  // WB     | single PC update      HALT   | halted until rst       STEP  | wait step (option)

  seq_state_e       state, state_nxt;
  logic             jmp_q, rjmp_q;
  logic [WIDTH-1:0] tgt_q, off_q, addr_q;
  logic             tmo_clr, tmo_en, tmo_term;
  logic             dec_take, tmo_fire;

  seq_timeout_ctr #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .load     (1'b0),
    .load_val ('0),
    .term     (tmo_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      jmp_q  <= 1'b0;
      rjmp_q <= 1'b0;
      tgt_q  <= '0;
      off_q  <= '0;
      addr_q <= '0;
      fault  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_LATCH) begin
        addr_q <= pc_loc;
      end
      if (dec_take) begin
        jmp_q  <= bus.dec_jump;
        rjmp_q <= bus.dec_rjump;
        tgt_q  <= bus.dec_target;
        off_q  <= bus.dec_offset;
      end
      if (tmo_fire) begin
        fault <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.PC_fetch = 1'b0;
    bus.jump     = 1'b0;
    bus.rjump    = 1'b0;
    bus.PC_wb_tr = 1'b0;
    bus.imem_req = 1'b0;
    bus.jump_loc = '0;
    bus.jump_inc = '0;
    halted       = 1'b0;
    tmo_en       = 1'b0;
    tmo_clr      = 1'b1;
    dec_take     = 1'b0;
    tmo_fire     = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.PC_fetch = 1'b1;
        state_nxt    = S_LATCH;
      end
      S_LATCH: begin
        state_nxt = S_MEM;
      end
      S_MEM: begin
        bus.imem_req = 1'b1;
        // An ack on the terminal cycle still completes the fetch.
        if (bus.imem_ack) begin
          state_nxt = S_DECODE;
        end else if (tmo_term) begin
          tmo_fire  = 1'b1;
          state_nxt = S_HALT;
        end else begin
          tmo_clr = 1'b0;
          tmo_en  = 1'b1;
        end
      end
      S_DECODE: begin
        if (bus.dec_valid) begin
          dec_take  = 1'b1;
          state_nxt = bus.dec_halt ? S_HALT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) state_nxt = S_WB;
      end
      S_WB: begin
        if (jmp_q) begin
          bus.jump     = 1'b1;
          bus.jump_loc = tgt_q;
        end else begin
          bus.PC_wb_tr = 1'b1;
          bus.rjump    = rjmp_q;
          bus.jump_inc = rjmp_q ? off_q : WIDTH'(1);
        end
`ifdef PC_SEQ_STEP_EN
        state_nxt = S_STEP;
`else
        state_nxt = run ? S_FETCH : S_IDLE;
`endif
      end
`ifdef PC_SEQ_STEP_EN
      S_STEP: begin
        if (!run) begin
          state_nxt = S_IDLE;
        end else if (step) begin
          state_nxt = S_FETCH;
        end
      end
`endif
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.imem_addr = addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: bench plays memory, decoder, execute unit and program_counter.
// Expected PC flow is computed per instruction from jump/relative/sequential rules.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
`ifdef PC_SEQ_STEP_EN
  logic            step = 1'b0;
`endif
  logic [WORD-1:0] pc_loc = '0;
  logic            halted;
  logic            fault;
  logic [WORD-1:0] model_pc = '0;
  int              vectors = 0;
  int              errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
`ifdef PC_SEQ_STEP_EN
    .step   (step),
`endif
    .pc_loc (pc_loc),
    .bus    (bus.master),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] strobes();
    return {bus.PC_fetch, bus.jump, bus.PC_wb_tr, bus.rjump};
  endfunction

  task automatic clear_inputs();
    bus.imem_ack   = 1'b0;
    bus.dec_valid  = 1'b0;
    bus.dec_jump   = 1'b0;
    bus.dec_rjump  = 1'b0;
    bus.dec_halt   = 1'b0;
    bus.dec_target = '0;
    bus.dec_offset = '0;
    bus.exec_done  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_pc(input logic [WORD-1:0] v);
    pc_loc   = v;
    model_pc = v;
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.PC_fetch !== 1'b1) begin
      errors++;
      $display("FAIL idle_to_fetch: PC_fetch=%b expected 1", bus.PC_fetch);
    end
  endtask

  // Entered on the FETCH cycle; leaves on the cycle after WB (or on HALT for a halt instruction).
  task automatic run_instr(input logic jmp, input logic rjmp, input logic hlt,
                           input int ack_dly, input int dec_dly, input int exec_dly,
                           input logic [WORD-1:0] tgt, input logic [WORD-1:0] off,
                           input logic run_next);
    logic [3:0]      exp_str;
    logic [WORD-1:0] exp_loc, exp_inc;
    vectors++;
    if (strobes() !== 4'b1000) begin
      errors++;
      $display("FAIL fetch_strobes: got %b expected 1000", strobes());
    end
    @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0000 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL latch_quiet: strobes=%b req=%b expected 0000/0", strobes(), bus.imem_req);
    end
    @(negedge clk);
    for (int i = 0; i <= ack_dly; i++) begin
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc || fault !== 1'b0) begin
        errors++;
        $display("FAIL mem_req: req=%b addr=%h fault=%b expected 1/%h/0",
                 bus.imem_req, bus.imem_addr, fault, model_pc);
      end
      bus.imem_ack = (i == ack_dly);
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    for (int j = 0; j <= dec_dly; j++) begin
      vectors++;
      if (bus.imem_req !== 1'b0 || strobes() !== 4'b0000 || halted !== 1'b0) begin
        errors++;
        $display("FAIL decode_wait: req=%b strobes=%b halted=%b expected 0/0000/0",
                 bus.imem_req, strobes(), halted);
      end
      if (j == dec_dly) begin
        bus.dec_valid  = 1'b1;
        bus.dec_jump   = jmp;
        bus.dec_rjump  = rjmp;
        bus.dec_halt   = hlt;
        bus.dec_target = tgt;
        bus.dec_offset = off;
      end else begin
        bus.dec_valid  = 1'b0;
        bus.dec_jump   = 1'($urandom);
        bus.dec_halt   = 1'($urandom);
        bus.dec_target = WORD'($urandom);
      end
      @(negedge clk);
    end
    bus.dec_valid  = 1'b0;
    bus.dec_jump   = 1'($urandom);
    bus.dec_rjump  = 1'($urandom);
    bus.dec_halt   = 1'($urandom);
    bus.dec_target = WORD'($urandom);
    bus.dec_offset = WORD'($urandom);
    if (hlt) begin
      vectors++;
      if (halted !== 1'b1 || strobes() !== 4'b0000 || fault !== 1'b0) begin
        errors++;
        $display("FAIL halt_entry: halted=%b strobes=%b fault=%b expected 1/0000/0",
                 halted, strobes(), fault);
      end
      return;
    end
    for (int k = 0; k <= exec_dly; k++) begin
      vectors++;
      if (strobes() !== 4'b0000 || halted !== 1'b0) begin
        errors++;
        $display("FAIL exec_wait: strobes=%b halted=%b expected 0000/0", strobes(), halted);
      end
      bus.exec_done = (k == exec_dly);
      @(negedge clk);
    end
    bus.exec_done = 1'b0;
    exp_str = jmp ? 4'b0100 : {3'b001, rjmp};
    exp_loc = jmp ? tgt : '0;
    exp_inc = jmp ? '0 : (rjmp ? off : WORD'(1));
    vectors++;
    if (strobes() !== exp_str) begin
      errors++;
      $display("FAIL wb_strobes: got %b expected %b", strobes(), exp_str);
    end
    vectors++;
    if (bus.jump_loc !== exp_loc || bus.jump_inc !== exp_inc) begin
      errors++;
      $display("FAIL wb_values: loc=%h inc=%h expected %h/%h",
               bus.jump_loc, bus.jump_inc, exp_loc, exp_inc);
    end
    if (bus.jump === 1'b1) pc_loc = bus.jump_loc;
    else if (bus.PC_wb_tr === 1'b1) pc_loc = pc_loc + bus.jump_inc;
    model_pc = jmp ? tgt : (rjmp ? model_pc + off : model_pc + WORD'(1));
    vectors++;
    if (pc_loc !== model_pc) begin
      errors++;
      $display("FAIL pc_update: pc=%h expected %h", pc_loc, model_pc);
    end
    run = run_next;
`ifdef PC_SEQ_STEP_EN
    @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0000) begin
      errors++;
      $display("FAIL step_hold: strobes=%b expected 0000", strobes());
    end
    if (run_next) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end else begin
      @(negedge clk);
    end
`else
    @(negedge clk);
`endif
    vectors++;
    if (bus.PC_fetch !== run_next || halted !== 1'b0) begin
      errors++;
      $display("FAIL after_wb: PC_fetch=%b halted=%b expected %b/0", bus.PC_fetch, halted, run_next);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    vectors++;
    if (strobes() !== 4'b0000 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: strobes=%b req=%b expected 0000/0", strobes(), bus.imem_req);
    end
    vectors++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: halted=%b fault=%b expected 0/0", halted, fault);
    end
    vectors++;
    if (bus.jump_loc !== '0 || bus.jump_inc !== '0 || bus.imem_addr !== '0) begin
      errors++;
      $display("FAIL reset_values: loc=%h inc=%h addr=%h expected 0/0/0",
               bus.jump_loc, bus.jump_inc, bus.imem_addr);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    set_pc('0);
    start_run();
    run_instr(1'b0, 1'b0, 1'b0, 2, 0, 0, '0, '0, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 2, 0, 0, '0, '0, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 2, 0, 0, '0, '0, 1'b0);
  endtask

  task automatic test_abs_jump();
    do_reset();
    set_pc(16'h0010);
    start_run();
    run_instr(1'b1, 1'b0, 1'b0, 0, 0, 0, 16'h0040, 16'h1234, 1'b1);
    run_instr(1'b1, 1'b1, 1'b0, 1, 1, 1, 16'h0100, 16'h0003, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, '0, '0, 1'b0);
  endtask

  task automatic test_rel_jump();
    do_reset();
    set_pc(16'h0005);
    start_run();
    run_instr(1'b0, 1'b1, 1'b0, 0, 0, 0, 16'hBEEF, 16'hFFFE, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, '0, '0, 1'b0);
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    set_pc(16'h0777);
    start_run();
    run_instr(1'b0, 1'b0, 1'b0, TMO - 1, 0, 0, '0, '0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    set_pc(16'h0123);
    start_run();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < TMO; i++) begin
      vectors++;
      if (bus.imem_req !== 1'b1 || fault !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait: cycle %0d req=%b fault=%b halted=%b expected 1/0/0",
                 i, bus.imem_req, fault, halted);
      end
      @(negedge clk);
    end
    vectors++;
    if ({fault, halted, bus.imem_req} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_fault: fault/halted/req=%b expected 110", {fault, halted, bus.imem_req});
    end
    for (int i = 0; i < 6; i++) begin
      run           = 1'($urandom);
      bus.imem_ack  = 1'($urandom);
      bus.dec_valid = 1'($urandom);
      bus.exec_done = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (strobes() !== 4'b0000 || {fault, halted} !== 2'b11) begin
        errors++;
        $display("FAIL timeout_hold: strobes=%b fault/halted=%b expected 0000/11",
                 strobes(), {fault, halted});
      end
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    set_pc(16'h0020);
    start_run();
    run_instr(1'b1, 1'b0, 1'b1, 1, 2, 0, 16'h0055, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      @(negedge clk);
      vectors++;
      if (strobes() !== 4'b0000 || halted !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold: strobes=%b halted=%b fault=%b expected 0000/1/0",
                 strobes(), halted, fault);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    vectors++;
    if ({strobes(), bus.imem_req, halted, fault} !== 7'b0 || bus.imem_addr !== '0) begin
      errors++;
      $display("FAIL halt_reset: outs=%b addr=%h expected 0000000/0",
               {strobes(), bus.imem_req, halted, fault}, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    set_pc(16'h0200);
    start_run();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.imem_req !== 1'b1) begin
        errors++;
        $display("FAIL midmem_req: cycle %0d req=%b expected 1", i, bus.imem_req);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({strobes(), bus.imem_req, halted, fault} !== 7'b0) begin
      errors++;
      $display("FAIL midmem_reset: outs=%b expected 0000000", {strobes(), bus.imem_req, halted, fault});
    end
    @(negedge clk);
    vectors++;
    if (bus.PC_fetch !== 1'b1) begin
      errors++;
      $display("FAIL midmem_restart: PC_fetch=%b expected 1", bus.PC_fetch);
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < TMO; i++) begin
      vectors++;
      if (bus.imem_req !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL midmem_count: cycle %0d req=%b fault=%b expected 1/0", i, bus.imem_req, fault);
      end
      @(negedge clk);
    end
    vectors++;
    if ({fault, halted} !== 2'b11) begin
      errors++;
      $display("FAIL midmem_timeout: fault/halted=%b expected 11", {fault, halted});
    end
  endtask

  task automatic test_random();
    int   kind;
    logic rn;
    do_reset();
    set_pc(WORD'($urandom));
    start_run();
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 3));
      rn   = ($urandom_range(0, 3) != 0);
      run_instr(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'b0,
                int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), WORD'($urandom), WORD'($urandom), rn);
      if (!rn) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          vectors++;
          if (bus.PC_fetch !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: PC_fetch=%b halted=%b expected 0/0", bus.PC_fetch, halted);
          end
        end
        start_run();
      end
    end
    run_instr(1'($urandom), 1'($urandom), 1'b1, 0, 1, 0, WORD'($urandom), WORD'($urandom), 1'b1);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sequential();
    test_abs_jump();
    test_rel_jump();
    test_ack_at_timeout();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-cycle controller for program_counter.
- Runs the FETCH/MEM/DECODE/EXECUTE/WRITEBACK loop.
- Drives the PC control strobes (PC_fetch, jump, PC_wb_tr), the jump target and the signed increment.
- Handshakes with instruction memory and the decode/execute units, so only one PC update is issued per instruction.

Parameters:
- WIDTH, `WORD (16), width of PC, addresses and offsets.
- MEM_TIMEOUT, 8, max cycles waiting for imem_ack before fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; sequencer leaves IDLE while high.
- pc_loc  in  WIDTH  program_counter location output.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  WIDTH  fetch address (registered copy of pc_loc).
- imem_ack  in  1  one-cycle memory response strobe.
- dec_valid  in  1  decoder result valid, one cycle.
- dec_jump  in  1  absolute jump.
- dec_rjump  in  1  relative jump.
- dec_halt  in  1  halt instruction.
- dec_target  in  WIDTH  absolute target.
- dec_offset  in  WIDTH  signed relative offset.
- exec_done  in  1  execute unit finished, one cycle.
- PC_fetch  out  1  to program_counter.
- jump  out  1  to program_counter.
- rjump  out  1  to program_counter (informational).
- jump_loc  out  WIDTH  to program_counter.
- jump_inc  out  WIDTH  signed, to program_counter.
- halted  out  1  HALT state.
- fault  out  1  sticky memory-timeout flag.

Behaviour:
- Reset: state=IDLE. All strobes, imem_req, halted and fault are 0. jump_loc=0, jump_inc=0, timeout counter=0.
- rst has priority over every other input, in any state, including mid-MEM.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH (1 cycle): assert PC_fetch=1, then go to LATCH.
- LATCH (1 cycle): capture imem_addr<=pc_loc, then go to MEM.
- MEM: imem_req=1 and counter increments each cycle.
  - If imem_ack: clear counter, drop imem_req, go to DECODE.
  - If counter reaches MEM_TIMEOUT-1 without ack: set fault=1, go to HALT.
  - An ack arriving in the same cycle as the timeout wins.
- DECODE: wait for dec_valid. Latch the flags, target and offset.
  - If dec_halt: go to HALT; halt overrides jump/rjump.
  - Otherwise go to EXEC.
- EXEC: wait for exec_done, then go to WB.
- WB (1 cycle), exactly one PC action:
  - dec_jump: jump=1, jump_loc=target, PC_wb_tr=0.
  - dec_rjump: PC_wb_tr=1, jump_inc=offset, rjump=1.
  - Otherwise: PC_wb_tr=1, jump_inc=1.
  - If jump and rjump are both set, jump wins.
  - Next state: FETCH if run=1, else IDLE.
- HALT: halted=1. Stay until rst. run is ignored.
- Strobes are never asserted together. PC_fetch is never asserted in the same cycle as jump or PC_wb_tr.
- Offset arithmetic is two's complement WIDTH bits; wrap-around is left to program_counter.
- Minimum instruction latency with ack, dec_valid and exec_done on their first cycle: 6 cycles FETCH→FETCH.

Optional Feature:
- Macro PC_SEQ_STEP_EN.
- Defined: adds input step, 1 bit. WB goes to a STEP state that waits for a step pulse before FETCH; run=0 in STEP goes to IDLE.
- Undefined: no step port, no STEP state, WB goes straight to FETCH.

Decomposition:
- Shared package / fmt.v include: the `WORD width, the state encoding constants (IDLE, FETCH, LATCH, MEM, DECODE, EXEC, WB, HALT, STEP) and the MEM_TIMEOUT default.
- One natural sub-module: seq_timeout_ctr, a loadable saturating counter with clear/enable and a terminal flag, used in MEM.

Test Plan:
- Sequential: run=1, ack after 2 cycles, dec plain, exec_done immediate → PC_wb_tr with jump_inc=1 each instruction; pc_loc advances 0,1,2.
- Absolute jump: dec_jump, target=0x0040 → WB has jump=1, jump_loc=0x0040, PC_wb_tr=0; next imem_addr=0x0040.
- Relative jump: dec_rjump, offset=0xFFFE (−2) at pc=5 → jump_inc=0xFFFE, PC_wb_tr=1; next imem_addr=3.
- Timeout: imem_ack never asserted → fault=1 and halted=1 after MEM_TIMEOUT=8 MEM cycles; no PC strobes after that.
- Halt precedence: dec_halt=1 with dec_jump=1 → HALT, no jump strobe; run toggling has no effect; rst returns to IDLE with all outputs 0.
- Reset mid-MEM: rst during imem_req=1 → next cycle state IDLE, imem_req=0, counter=0; fault stays cleared.
